// File: rtl/alu_pkg.sv
// Shared types and widths for the execute-stage ALU and its HI/LO unit.
package alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FUNC_W  = 5;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [FUNC_W-1:0] {
        F_ADDU  = 5'd0,
        F_AND   = 5'd1,
        F_OR    = 5'd2,
        F_SUBU  = 5'd3,
        F_SLT   = 5'd4,
        F_SLTU  = 5'd5,
        F_SLL   = 5'd6,
        F_SLLV  = 5'd7,
        F_SRL   = 5'd8,
        F_SRLV  = 5'd9,
        F_SRA   = 5'd10,
        F_SRAV  = 5'd11,
        F_XOR   = 5'd12,
        F_NOR   = 5'd13,
        F_LUI   = 5'd14,
        F_MULT  = 5'd16,
        F_MULTU = 5'd17,
        F_DIV   = 5'd18,
        F_DIVU  = 5'd19,
        F_MTHI  = 5'd20,
        F_MTLO  = 5'd21,
        F_MFHI  = 5'd22,
        F_MFLO  = 5'd23
    } alu_func_t;

    // Most negative signed operand; the only dividend that can overflow.
    localparam logic [DATA_W-1:0] SIGN_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the execute stage and the ALU.
interface alu_if;
    import alu_pkg::*;

    logic                en;
    logic [FUNC_W-1:0]   alu_func;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [SHAMT_W-1:0]  shift;
    logic [DATA_W-1:0]   result;
    logic                zero;

    modport master (
        output en, alu_func, a, b, shift,
        input  result, zero
    );

    modport slave (
        input  en, alu_func, a, b, shift,
        output result, zero
    );

endinterface

// File: rtl/alu_hilo.sv
// HI/LO register pair with single-cycle multiply, divide and move-to datapath.
module alu_hilo
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_en,
    input  logic [FUNC_W-1:0]  i_func,
    input  logic [DATA_W-1:0]  i_a,
    input  logic [DATA_W-1:0]  i_b,
    output logic [DATA_W-1:0]  o_hi,
    output logic [DATA_W-1:0]  o_lo
);

    logic [DATA_W-1:0]          r_hi;
    logic [DATA_W-1:0]          r_lo;

    logic [2*DATA_W-1:0]        w_prod_s;
    logic [2*DATA_W-1:0]        w_prod_u;
    logic                       w_div_zero;
    logic                       w_div_ovf;
    logic signed [DATA_W-1:0]   w_a_s;
    logic signed [DATA_W-1:0]   w_div_s;
    logic signed [DATA_W-1:0]   w_quo_s;
    logic signed [DATA_W-1:0]   w_rem_s;
    logic [DATA_W-1:0]          w_div_u;
    logic [DATA_W-1:0]          w_quo_u;
    logic [DATA_W-1:0]          w_rem_u;

    logic                       w_hi_we;
    logic                       w_lo_we;
    logic [DATA_W-1:0]          w_hi_nxt;
    logic [DATA_W-1:0]          w_lo_nxt;

    assign w_prod_s = $signed({{DATA_W{i_a[DATA_W-1]}}, i_a})
                    * $signed({{DATA_W{i_b[DATA_W-1]}}, i_b});
    assign w_prod_u = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

    // Divisor forced to 1 on /0 and on MIN/-1: the former is discarded,
    // the latter then yields exactly quotient=MIN, remainder=0.
    assign w_div_zero = (i_b == '0);
    assign w_div_ovf  = (i_a == SIGN_MIN) && (i_b == '1);
    assign w_a_s      = i_a;
    assign w_div_s    = (w_div_zero || w_div_ovf) ? DATA_W'(1) : i_b;
    assign w_quo_s    = w_a_s / w_div_s;
    assign w_rem_s    = w_a_s % w_div_s;
    assign w_div_u    = w_div_zero ? DATA_W'(1) : i_b;
    assign w_quo_u    = i_a / w_div_u;
    assign w_rem_u    = i_a % w_div_u;

    // Next-value and write-enable select per function code.
    always_comb begin
        w_hi_we  = 1'b0;
        w_lo_we  = 1'b0;
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        case (i_func)
            F_MULT: begin
                w_hi_we  = 1'b1;
                w_lo_we  = 1'b1;
                w_hi_nxt = w_prod_s[2*DATA_W-1:DATA_W];
                w_lo_nxt = w_prod_s[DATA_W-1:0];
            end
            F_MULTU: begin
                w_hi_we  = 1'b1;
                w_lo_we  = 1'b1;
                w_hi_nxt = w_prod_u[2*DATA_W-1:DATA_W];
                w_lo_nxt = w_prod_u[DATA_W-1:0];
            end
            F_DIV: begin
                w_hi_we  = !w_div_zero;
                w_lo_we  = !w_div_zero;
                w_hi_nxt = w_rem_s;
                w_lo_nxt = w_quo_s;
            end
            F_DIVU: begin
                w_hi_we  = !w_div_zero;
                w_lo_we  = !w_div_zero;
                w_hi_nxt = w_rem_u;
                w_lo_nxt = w_quo_u;
            end
            F_MTHI: begin
                w_hi_we  = 1'b1;
                w_hi_nxt = i_a;
            end
            F_MTLO: begin
                w_lo_we  = 1'b1;
                w_lo_nxt = i_a;
            end
            default: begin
                w_hi_we  = 1'b0;
                w_lo_we  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (i_en) begin
            if (w_hi_we) r_hi <= w_hi_nxt;
            if (w_lo_we) r_lo <= w_lo_nxt;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: combinational operation mux and zero detect around HI/LO.
module alu
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    alu_if.slave  bus
);

    logic [DATA_W-1:0]  w_hi;
    logic [DATA_W-1:0]  w_lo;
    logic [DATA_W-1:0]  w_result;
    logic [SHAMT_W-1:0] w_shamt_v;

    alu_hilo u_hilo (
        .clk    (clk),
        .reset  (reset),
        .i_en   (bus.en),
        .i_func (bus.alu_func),
        .i_a    (bus.a),
        .i_b    (bus.b),
        .o_hi   (w_hi),
        .o_lo   (w_lo)
    );

    assign w_shamt_v = bus.b[SHAMT_W-1:0];

    // HI/LO-writing codes and unassigned codes fall through to zero.
    always_comb begin
        w_result = '0;
        case (bus.alu_func)
            F_ADDU:  w_result = bus.a + bus.b;
            F_AND:   w_result = bus.a & bus.b;
            F_OR:    w_result = bus.a | bus.b;
            F_SUBU:  w_result = bus.a - bus.b;
            F_SLT:   w_result = DATA_W'($signed(bus.a) < $signed(bus.b));
            F_SLTU:  w_result = DATA_W'(bus.a < bus.b);
            F_SLL:   w_result = bus.a << bus.shift;
            F_SLLV:  w_result = bus.a << w_shamt_v;
            F_SRL:   w_result = bus.a >> bus.shift;
            F_SRLV:  w_result = bus.a >> w_shamt_v;
            F_SRA:   w_result = DATA_W'($signed(bus.a) >>> bus.shift);
            F_SRAV:  w_result = DATA_W'($signed(bus.a) >>> w_shamt_v);
            F_XOR:   w_result = bus.a ^ bus.b;
            F_NOR:   w_result = ~(bus.a | bus.b);
            F_LUI:   w_result = {bus.b[15:0], 16'h0000};
            F_MFHI:  w_result = w_hi;
            F_MFLO:  w_result = w_lo;
            default: w_result = '0;
        endcase
    end

    assign bus.result = w_result;
    assign bus.zero   = (w_result == '0);

endmodule

// File: tb/tb_alu.sv
// Randomized and directed check of alu against an arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    alu_if bus ();

    alu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input int f, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [4:0] sh);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'(a);
        longint ub = longint'(b);
        case (f)
            0:  return 32'(ua + ub);
            1:  return a & b;
            2:  return a | b;
            3:  return 32'(ua - ub);
            4:  return (sa < sb) ? 32'd1 : 32'd0;
            5:  return (ua < ub) ? 32'd1 : 32'd0;
            6:  return 32'(ua * (64'd1 << sh));
            7:  return 32'(ua * (64'd1 << b[4:0]));
            8:  return 32'(ua / (64'd1 << sh));
            9:  return 32'(ua / (64'd1 << b[4:0]));
            10: return 32'(sa >>> sh);
            11: return 32'(sa >>> b[4:0]);
            12: return a ^ b;
            13: return ~(a | b);
            14: return 32'(ub * 65536);
            22: return m_hi;
            23: return m_lo;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_clock(input int f, input logic [31:0] a, input logic [31:0] b,
                               input logic en, input logic rst);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint unsigned pu;
        longint ps;
        if (rst) begin
            m_hi = 32'h0;
            m_lo = 32'h0;
        end else if (en) begin
            case (f)
                16: begin ps = sa * sb; m_hi = 32'(ps >>> 32); m_lo = 32'(ps); end
                17: begin
                    pu = longint'(a) * longint'(b);
                    m_hi = 32'(pu >> 32);
                    m_lo = 32'(pu);
                end
                18: if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
                19: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
                20: m_hi = a;
                21: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // One cycle: drive, check combinational outputs, clock, advance the model.
    task automatic run_op(input string tag, input int f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          input logic en, input logic rst,
                          input bit use_want, input logic [31:0] want);
        logic [31:0] exp;
        bus.alu_func = 5'(f);
        bus.a        = a;
        bus.b        = b;
        bus.shift    = sh;
        bus.en       = en;
        reset        = rst;
        #2;
        exp = model_result(f, a, b, sh);
        check({tag, ".res"}, bus.result, exp);
        check({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, exp == 32'h0});
        if (use_want) check({tag, ".want"}, bus.result, want);
        @(posedge clk);
        model_clock(f, a, b, en, rst);
        #1;
    endtask

    task automatic expect_op(input string tag, input int f, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] sh, input logic [31:0] want);
        run_op(tag, f, a, b, sh, 1'b0, 1'b0, 1'b1, want);
    endtask

    task automatic write_op(input string tag, input int f, input logic [31:0] a,
                            input logic [31:0] b, input logic en, input logic rst);
        run_op(tag, f, a, b, 5'd0, en, rst, 1'b1, 32'h0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        bus.en = 1'b0; bus.alu_func = 5'd0; bus.a = '0; bus.b = '0; bus.shift = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        write_op("rst0", 0, 0, 0, 1'b1, 1'b1);
        write_op("rst1", 0, 0, 0, 1'b1, 1'b1);
        expect_op("rst_hi", 22, 0, 0, 0, 32'h0);
        expect_op("rst_lo", 23, 0, 0, 0, 32'h0);

        expect_op("addu", 0,  32'h0F, 32'hF0, 0, 32'hFF);
        expect_op("and",  1,  32'h0F, 32'hF0, 0, 32'h0);
        expect_op("or",   2,  32'h0F, 32'hF0, 0, 32'hFF);
        expect_op("xor",  12, 32'h0F, 32'hF0, 0, 32'hFF);
        expect_op("nor",  13, 32'h0F, 32'hF0, 0, 32'hFFFF_FF00);
        expect_op("subu", 3,  32'h0F, 32'h0F, 0, 32'h0);
        expect_op("slt1", 4,  32'h0F, 32'hFFFF, 0, 32'h1);
        expect_op("sltu0", 5, 32'h0F, 32'h0F, 0, 32'h0);
        expect_op("slt_neg", 4,  32'h1, 32'hFFFF_FFFF, 0, 32'h0);
        expect_op("sltu_big", 5, 32'h1, 32'hFFFF_FFFF, 0, 32'h1);
        expect_op("sll",  6,  32'h0F, 32'h2, 2, 32'h3C);
        expect_op("sllv", 7,  32'h0F, 32'h2, 2, 32'h3C);
        expect_op("srl",  8,  32'h0F, 32'h2, 2, 32'h3);
        expect_op("srlv", 9,  32'h0F, 32'h2, 2, 32'h3);
        expect_op("sra",  10, 32'hFFFF_FFFF, 32'h2, 2, 32'hFFFF_FFFF);
        expect_op("srav", 11, 32'hC, 32'h2, 2, 32'h3);
        expect_op("srl31", 8,  32'h8000_0000, 0, 31, 32'h1);
        expect_op("sra31", 10, 32'h8000_0000, 0, 31, 32'hFFFF_FFFF);
        expect_op("sll0", 6,  32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF);
        expect_op("lui",  14, 0, 32'h1234_ABCD, 0, 32'hABCD_0000);
        expect_op("code15", 15, 32'h5, 32'h7, 0, 32'h0);
        expect_op("code31", 31, 32'h5, 32'h7, 0, 32'h0);

        write_op("mult", 16, 32'hFFFF_FFFE, 32'h3, 1'b1, 1'b0);
        expect_op("mult_hi", 22, 0, 0, 0, 32'hFFFF_FFFF);
        expect_op("mult_lo", 23, 0, 0, 0, 32'hFFFF_FFFA);
        write_op("multu", 17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        expect_op("multu_hi", 22, 0, 0, 0, 32'hFFFF_FFFE);
        expect_op("multu_lo", 23, 0, 0, 0, 32'h1);
        write_op("div", 18, 32'hFFFF_FFF9, 32'h2, 1'b1, 1'b0);
        expect_op("div_lo", 23, 0, 0, 0, 32'hFFFF_FFFD);
        expect_op("div_hi", 22, 0, 0, 0, 32'hFFFF_FFFF);
        write_op("divu0", 19, 32'h55, 32'h0, 1'b1, 1'b0);
        expect_op("divu0_hi", 22, 0, 0, 0, 32'hFFFF_FFFF);
        expect_op("divu0_lo", 23, 0, 0, 0, 32'hFFFF_FFFD);
        write_op("divovf", 18, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        expect_op("divovf_lo", 23, 0, 0, 0, 32'h8000_0000);
        expect_op("divovf_hi", 22, 0, 0, 0, 32'h0);
        write_op("mthi_en0", 20, 32'h1234, 0, 1'b0, 1'b0);
        expect_op("mthi_en0_hi", 22, 0, 0, 0, 32'h0);
        write_op("mthi_en1", 20, 32'h1234, 0, 1'b1, 1'b0);
        expect_op("mthi_en1_hi", 22, 0, 0, 0, 32'h1234);
        write_op("mtlo", 21, 32'h9876, 0, 1'b1, 1'b0);
        expect_op("mtlo_lo", 23, 0, 0, 0, 32'h9876);
        write_op("mthi_rst", 20, 32'h4321, 0, 1'b1, 1'b1);
        expect_op("mthi_rst_hi", 22, 0, 0, 0, 32'h0);
        expect_op("mthi_rst_lo", 23, 0, 0, 0, 32'h0);

        for (int i = 0; i < 600; i++) begin
            run_op("rand", int'($urandom_range(0, 31)), pick(), pick(),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 39) == 0), 1'b0, 32'h0);
            if ((i % 8) == 7) begin
                run_op("rand_hi", 22, pick(), pick(), 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
                run_op("rand_lo", 23, pick(), pick(), 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
